// File: rtl/drain_scheduler_pkg.sv
// Shared definitions for the drain scheduler: state encoding and default geometry.
// The control unit and the bench import this to decode drain progress.
package drain_scheduler_pkg;

    localparam int DEFAULT_ARRAY_SIZE = 4;
    localparam int DEFAULT_ADDR_WIDTH = 16;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_WAIT_DONE = 3'd1,
        ST_CAPTURE   = 3'd2,
        ST_WRITE     = 3'd3,
        ST_DONE      = 3'd4
    } drain_state_t;

endpackage

// File: rtl/drain_scheduler.sv
// Sequences the systolic-array drain: alternates PPU capture and UB write per row,
// and arbitrates the unified-buffer write port with host writes (drain wins).
module drain_scheduler
    import drain_scheduler_pkg::*;
#(
    parameter int ARRAY_SIZE     = DEFAULT_ARRAY_SIZE,
    parameter int ADDR_WIDTH     = DEFAULT_ADDR_WIDTH,
    parameter int TIMEOUT_CYCLES = 1024,
    localparam int IDX_W         = (ARRAY_SIZE > 1) ? $clog2(ARRAY_SIZE) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] dst_base_addr,
    input  logic                  sa_all_done,
    input  logic                  host_wr_req,
    input  logic [ADDR_WIDTH-1:0] host_wr_addr,
    output logic                  host_wr_grant,
    output logic                  drain_enable,
    output logic                  ppu_capture_en,
    output logic [IDX_W-1:0]      ppu_cycle_idx,
    output logic                  ub_wr_en,
    output logic [ADDR_WIDTH-1:0] ub_wr_addr,
    output logic                  busy,
    output logic                  done,
    output logic                  timeout_err
);

    localparam int WAIT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    drain_state_t          state_q, state_d;
    logic [IDX_W-1:0]      row_q, row_d;
    logic [WAIT_W-1:0]     wait_q, wait_d;
    logic [ADDR_WIDTH-1:0] base_q, base_d;
    logic                  tmo_q, tmo_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            row_q   <= '0;
            wait_q  <= '0;
            base_q  <= '0;
            tmo_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            wait_q  <= wait_d;
            base_q  <= base_d;
            tmo_q   <= tmo_d;
        end
    end

    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        wait_d  = wait_q;
        base_d  = base_q;
        tmo_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_WAIT_DONE;
                    base_d  = dst_base_addr;
                    row_d   = '0;
                    wait_d  = '0;
                end
            end
            ST_WAIT_DONE: begin
                if (sa_all_done) begin
                    state_d = ST_CAPTURE;
                end else if (wait_q == WAIT_W'(TIMEOUT_CYCLES - 1)) begin
                    state_d = ST_IDLE;
                    tmo_d   = 1'b1;
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end
            ST_CAPTURE: state_d = ST_WRITE;
            ST_WRITE: begin
                if (row_q == IDX_W'(ARRAY_SIZE - 1)) begin
                    state_d = ST_DONE;
                end else begin
                    row_d   = row_q + IDX_W'(1);
                    state_d = ST_CAPTURE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // The timeout pulse is registered, so it appears the cycle the block is back in IDLE.
    assign timeout_err    = tmo_q;
    assign busy           = (state_q != ST_IDLE);
    assign done           = (state_q == ST_DONE);
    assign ppu_capture_en = (state_q == ST_CAPTURE);
    assign drain_enable   = (state_q == ST_WRITE);
    assign ppu_cycle_idx  = (state_q == ST_CAPTURE || state_q == ST_WRITE) ? row_q : '0;

    // Host writes slip into any non-WRITE cycle; a stalled requester keeps req high.
    assign host_wr_grant  = host_wr_req && (state_q != ST_WRITE) && !rst;
    assign ub_wr_en       = !rst && (drain_enable || host_wr_grant);

    always_comb begin
        ub_wr_addr = '0;
        if (!rst) begin
            if (drain_enable) begin
                ub_wr_addr = base_q + ADDR_WIDTH'(row_q);
            end else if (host_wr_grant) begin
                ub_wr_addr = host_wr_addr;
            end
        end
    end

endmodule

// File: tb/tb_drain_scheduler.sv
// Self-checking bench for drain_scheduler: table-driven basic drain, directed corner
// sequences, and randomized traffic against a cycle-arithmetic reference model.
module tb_drain_scheduler;

    localparam int N   = 4;
    localparam int AW  = 16;
    localparam int TO  = 64;
    localparam int TO8 = 8;

    logic          clk, rst, start, sa_all_done, host_wr_req;
    logic [AW-1:0] dst_base_addr, host_wr_addr;

    logic          grant, drain, cap, wr, busy, done, tmo;
    logic [1:0]    idx;
    logic [AW-1:0] addr;

    logic          t8_grant, t8_drain, t8_cap, t8_wr, t8_busy, t8_done, t8_tmo;
    logic [1:0]    t8_idx;
    logic [AW-1:0] t8_addr;

    drain_scheduler #(.ARRAY_SIZE(N), .ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst), .start(start), .dst_base_addr(dst_base_addr),
        .sa_all_done(sa_all_done), .host_wr_req(host_wr_req), .host_wr_addr(host_wr_addr),
        .host_wr_grant(grant), .drain_enable(drain), .ppu_capture_en(cap),
        .ppu_cycle_idx(idx), .ub_wr_en(wr), .ub_wr_addr(addr), .busy(busy),
        .done(done), .timeout_err(tmo)
    );

    drain_scheduler #(.ARRAY_SIZE(N), .ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TO8)) dut_t8 (
        .clk(clk), .rst(rst), .start(start), .dst_base_addr(dst_base_addr),
        .sa_all_done(sa_all_done), .host_wr_req(host_wr_req), .host_wr_addr(host_wr_addr),
        .host_wr_grant(t8_grant), .drain_enable(t8_drain), .ppu_capture_en(t8_cap),
        .ppu_cycle_idx(t8_idx), .ub_wr_en(t8_wr), .ub_wr_addr(t8_addr), .busy(t8_busy),
        .done(t8_done), .timeout_err(t8_tmo)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_tests;
    int n_fail;
    int cyc;

    // Reference model: a drain is "active" from WAIT entry; once sa_all_done is seen,
    // the whole drain timeline is fixed arithmetic relative to the first capture cycle.
    bit            m_active;
    int            m_entry;
    int            m_cap0;
    int            m_tmo_cyc;
    logic [AW-1:0] m_base;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got 0x%0h expected 0x%0h", name, cyc, act, exp);
        end
    endtask

    task automatic model_check();
        logic          e_busy, e_cap, e_done, e_grant, e_wr, e_tmo, in_write;
        logic [1:0]    e_idx;
        logic [AW-1:0] e_addr;
        int            k;
        e_busy = 0; e_cap = 0; e_done = 0; in_write = 0; e_idx = 0; k = 0;
        e_tmo  = (cyc == m_tmo_cyc);
        if (m_active) begin
            e_busy = 1;
            if (m_cap0 >= 0 && cyc >= m_cap0) begin
                k = cyc - m_cap0;
                if (k < 2 * N) begin
                    e_idx = 2'(k / 2);
                    if (k % 2 == 0) e_cap = 1;
                    else            in_write = 1;
                end else begin
                    e_done = 1;
                end
            end
        end
        e_grant = host_wr_req && !in_write && !rst;
        e_wr    = !rst && (in_write || e_grant);
        if (!e_wr)         e_addr = '0;
        else if (in_write) e_addr = m_base + AW'(k / 2);
        else               e_addr = host_wr_addr;
        chk("mdl_busy",  32'(busy),  32'(e_busy));
        chk("mdl_cap",   32'(cap),   32'(e_cap));
        chk("mdl_drain", 32'(drain), 32'(in_write));
        chk("mdl_idx",   32'(idx),   32'(e_idx));
        chk("mdl_done",  32'(done),  32'(e_done));
        chk("mdl_tmo",   32'(tmo),   32'(e_tmo));
        chk("mdl_grant", 32'(grant), 32'(e_grant));
        chk("mdl_wr_en", 32'(wr),    32'(e_wr));
        chk("mdl_addr",  32'(addr),  32'(e_addr));
    endtask

    task automatic model_update();
        if (rst) begin
            m_active = 0; m_cap0 = -1; m_base = '0; m_tmo_cyc = -1;
        end else if (!m_active) begin
            if (start) begin
                m_active = 1; m_entry = cyc + 1; m_cap0 = -1; m_base = dst_base_addr;
            end
        end else if (m_cap0 < 0) begin
            if (sa_all_done) m_cap0 = cyc + 1;
            else if (cyc - m_entry == TO - 1) begin
                m_active = 0; m_tmo_cyc = cyc + 1;
            end
        end else if (cyc - m_cap0 == 2 * N) begin
            m_active = 0;
        end
    endtask

    task automatic sample();
        @(negedge clk);
        model_check();
    endtask

    task automatic advance();
        @(posedge clk);
        model_update();
        cyc++;
        #1;
    endtask

    task automatic do_reset();
        rst = 1; start = 0; sa_all_done = 0; host_wr_req = 0;
        sample(); advance();
        sample(); advance();
        rst = 0;
    endtask

    typedef struct {
        logic          start;
        logic [AW-1:0] base;
        logic          busy, cap, wr, done;
        logic [1:0]    idx;
        logic [AW-1:0] addr;
    } vec_t;

    vec_t          tbl[12];
    logic [AW-1:0] wrap_exp[4];

    initial begin
        n_tests = 0; n_fail = 0; cyc = 0;
        m_active = 0; m_cap0 = -1; m_tmo_cyc = -1; m_base = '0; m_entry = 0;
        rst = 1; start = 0; sa_all_done = 0; host_wr_req = 0;
        dst_base_addr = '0; host_wr_addr = '0;

        // Basic drain timeline: captures in cycles 2,4,6,8, writes in 3,5,7,9, done in 10.
        for (int r = 0; r < 12; r++) begin
            tbl[r].start = (r == 0);
            tbl[r].base  = 16'h0100;
            tbl[r].busy  = (r >= 1 && r <= 10);
            tbl[r].cap   = 0; tbl[r].wr = 0; tbl[r].done = (r == 10);
            tbl[r].idx   = 0; tbl[r].addr = '0;
        end
        for (int i = 0; i < 4; i++) begin
            tbl[2 + 2 * i].cap  = 1;
            tbl[2 + 2 * i].idx  = 2'(i);
            tbl[3 + 2 * i].wr   = 1;
            tbl[3 + 2 * i].idx  = 2'(i);
            tbl[3 + 2 * i].addr = 16'h0100 + 16'(i);
        end
        wrap_exp[0] = 16'hFFFE; wrap_exp[1] = 16'hFFFF;
        wrap_exp[2] = 16'h0000; wrap_exp[3] = 16'h0001;

        do_reset();
        sample();
        chk("reset_busy",  32'(busy),  0);
        chk("reset_done",  32'(done),  0);
        chk("reset_cap",   32'(cap),   0);
        chk("reset_drain", 32'(drain), 0);
        chk("reset_idx",   32'(idx),   0);
        chk("reset_wr",    32'(wr),    0);
        chk("reset_addr",  32'(addr),  0);
        chk("reset_tmo",   32'(tmo),   0);
        advance();

        sa_all_done = 1;
        for (int r = 0; r < 12; r++) begin
            start = tbl[r].start; dst_base_addr = tbl[r].base;
            sample();
            chk("basic_busy", 32'(busy), 32'(tbl[r].busy));
            chk("basic_cap",  32'(cap),  32'(tbl[r].cap));
            chk("basic_wr",   32'(wr),   32'(tbl[r].wr));
            chk("basic_done", 32'(done), 32'(tbl[r].done));
            chk("basic_idx",  32'(idx),  32'(tbl[r].idx));
            chk("basic_addr", 32'(addr), 32'(tbl[r].addr));
            advance();
        end
        start = 0;

        // Late done: sa_all_done arrives 20 cycles after start, then drops during the drain.
        do_reset();
        start = 1; sa_all_done = 0; dst_base_addr = 16'h0400;
        sample(); advance();
        start = 0;
        for (int r = 1; r <= 20; r++) begin
            sample();
            chk("late_busy", 32'(busy), 1);
            chk("late_cap",  32'(cap),  0);
            advance();
        end
        sa_all_done = 1;
        sample(); advance();
        sa_all_done = 0;
        for (int k = 0; k < 10; k++) begin
            sample();
            if (k == 0) chk("late_first_capture", 32'(cap), 1);
            chk("late_busy_drain", 32'(busy), 32'(k <= 8));
            chk("late_done", 32'(done), 32'(k == 8));
            advance();
        end

        // Timeout on the short-timeout instance: pulse 8 cycles after WAIT_DONE entry.
        do_reset();
        start = 1; sa_all_done = 0; dst_base_addr = 16'h0500;
        for (int r = 0; r <= 12; r++) begin
            sample();
            chk("tmo_pulse", 32'(t8_tmo),  32'(r == 9));
            chk("tmo_no_wr", 32'(t8_wr),   0);
            chk("tmo_busy",  32'(t8_busy), 32'(r >= 1 && r <= 8));
            chk("tmo_done",  32'(t8_done), 0);
            advance();
            start = 0;
        end

        // Arbitration: host request held through a whole drain.
        do_reset();
        host_wr_req = 1; host_wr_addr = 16'h0050; sa_all_done = 1;
        start = 1; dst_base_addr = 16'h0200;
        for (int r = 0; r < 12; r++) begin
            logic is_wr;
            is_wr = (r == 3 || r == 5 || r == 7 || r == 9);
            sample();
            chk("arb_grant", 32'(grant), 32'(!is_wr));
            chk("arb_drain", 32'(drain), 32'(is_wr));
            chk("arb_wr_en", 32'(wr), 1);
            if (!is_wr) chk("arb_host_addr", 32'(addr), 32'h0050);
            else        chk("arb_drain_addr", 32'(addr), 32'(16'h0200 + 16'((r - 3) / 2)));
            advance();
            start = 0;
        end
        host_wr_req = 0;

        // Address wrap, with a second start mid-drain that must be ignored.
        do_reset();
        sa_all_done = 1; start = 1; dst_base_addr = 16'hFFFE;
        for (int r = 0; r < 12; r++) begin
            sample();
            if (r >= 3 && r <= 9 && (r % 2 == 1)) begin
                chk("wrap_wr",   32'(wr),   1);
                chk("wrap_addr", 32'(addr), 32'(wrap_exp[(r - 3) / 2]));
            end
            chk("wrap_done", 32'(done), 32'(r == 10));
            advance();
            start = (r == 4);
            dst_base_addr = (r == 4) ? 16'h1234 : 16'hFFFE;
        end
        start = 0;

        // Reset asserted during the second WRITE; no completion may follow.
        do_reset();
        sa_all_done = 1; start = 1; dst_base_addr = 16'h0300;
        for (int r = 0; r < 5; r++) begin
            sample(); advance();
            start = 0;
        end
        rst = 1;
        sample();
        chk("rstmid_wr_en", 32'(wr),    0);
        chk("rstmid_grant", 32'(grant), 0);
        advance();
        rst = 0;
        sample();
        chk("rstmid_busy",  32'(busy),  0);
        chk("rstmid_drain", 32'(drain), 0);
        chk("rstmid_wr",    32'(wr),    0);
        chk("rstmid_addr",  32'(addr),  0);
        chk("rstmid_idx",   32'(idx),   0);
        advance();
        for (int r = 0; r < 8; r++) begin
            sample();
            chk("rstmid_no_done", 32'(done), 0);
            advance();
        end
        start = 1; dst_base_addr = 16'h0310;
        for (int r = 0; r < 12; r++) begin
            sample();
            if (r >= 3 && r <= 9 && (r % 2 == 1))
                chk("restart_addr", 32'(addr), 32'(16'h0310 + 16'((r - 3) / 2)));
            chk("restart_done", 32'(done), 32'(r == 10));
            advance();
            start = 0;
        end

        // Randomized traffic checked cycle by cycle against the model.
        for (int i = 0; i < 3000; i++) begin
            rst          = ($urandom_range(0, 199) == 0);
            start        = ($urandom_range(0, 7) == 0);
            dst_base_addr = AW'($urandom);
            if ($urandom_range(0, 39) == 0) sa_all_done = ~sa_all_done;
            host_wr_req  = ($urandom_range(0, 2) == 0);
            host_wr_addr = AW'($urandom);
            sample();
            advance();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/drain_scheduler.md
DRAIN_SCHEDULER -- requirements
Module: drain_scheduler

Interface
REQ-001 Parameter ARRAY_SIZE, default 4, systolic array dimension and drain row count.
REQ-002 Parameter ADDR_WIDTH, default 16, unified buffer address width.
REQ-003 Parameter TIMEOUT_CYCLES, default 1024, maximum WAIT_DONE dwell before error.
REQ-004 clk  input  1  single clock; all state changes on rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 start  input  1  one-cycle request to drain the array.
REQ-007 dst_base_addr  input  ADDR_WIDTH  first UB row address for results; sampled when start is accepted.
REQ-008 sa_all_done  input  1  array computation complete, level.
REQ-009 host_wr_req  input  1  host/MMIO write request to UB.
REQ-010 host_wr_addr  input  ADDR_WIDTH  host write address.
REQ-011 host_wr_grant  output  1  host write issued this cycle.
REQ-012 drain_enable  output  1  array shift plus UB write-data select of PPU data.
REQ-013 ppu_capture_en  output  1  PPU captures bottom accumulator row.
REQ-014 ppu_cycle_idx  output  clog2(ARRAY_SIZE)  current drain row index.
REQ-015 ub_wr_en  output  1  UB write strobe.
REQ-016 ub_wr_addr  output  ADDR_WIDTH  UB write address.
REQ-017 busy  output  1  high in every state except IDLE.
REQ-018 done  output  1  one-cycle pulse on drain completion.
REQ-019 timeout_err  output  1  one-cycle pulse on WAIT_DONE timeout.

Function
REQ-020 States are IDLE, WAIT_DONE, CAPTURE, WRITE, DONE; outputs decode from registered state, row counter and latched base only, except host_wr_grant, ub_wr_en and ub_wr_addr.
REQ-021 Transitions are as follows.
- IDLE to WAIT_DONE on start, latching dst_base_addr, row=0 and wait counter=0.
- WAIT_DONE to CAPTURE when sa_all_done=1.
- WAIT_DONE to IDLE with timeout_err pulse when the wait counter reaches TIMEOUT_CYCLES-1 and sa_all_done=0.
- CAPTURE to WRITE.
- WRITE to DONE if row==ARRAY_SIZE-1, else row+1 and back to CAPTURE.
- DONE to IDLE.
REQ-022 CAPTURE drives ppu_capture_en=1 and ppu_cycle_idx=row; drain_enable=0.
REQ-023 WRITE drives drain_enable=1, ub_wr_en=1, ub_wr_addr=(base+row) mod 2^ADDR_WIDTH, ppu_cycle_idx=row.
REQ-024 DONE drives done=1 for exactly one cycle.
REQ-025 Latency: start accepted in cycle 0, sa_all_done already high, gives CAPTURE row 0 in cycle 2, last WRITE in cycle 2*ARRAY_SIZE+1, and done in cycle 2*ARRAY_SIZE+2.
REQ-026 start while busy=1 is ignored; dst_base_addr is not re-latched.
REQ-027 host_wr_grant = host_wr_req AND state!=WRITE; drain writes have strict priority.
REQ-028 When host_wr_grant=1: ub_wr_en=1, ub_wr_addr=host_wr_addr, drain_enable=0.
REQ-029 A host write during WRITE is stalled, not dropped; the requester holds host_wr_req until granted.
REQ-030 ppu_cycle_idx is 0 in IDLE, WAIT_DONE and DONE.
REQ-031 sa_all_done deasserting during CAPTURE or WRITE does not affect sequencing.
REQ-032 Address addition wraps modulo 2^ADDR_WIDTH with no error.

Reset
REQ-033 On rst=1 at a clock edge, the state returns to IDLE from any state, including mid-drain.
REQ-034 On that edge, row=0, wait counter=0 and latched base=0.
REQ-035 On that edge, every registered output clears to 0: busy, done, timeout_err, drain_enable, ppu_capture_en, ppu_cycle_idx, ub_wr_en and ub_wr_addr.
REQ-036 While rst=1, host_wr_grant=0 and ub_wr_en=0.
REQ-037 No partial-drain completion is signalled after reset.

Structure
REQ-038 The state enumeration drain_state_t goes in the team shared defines header, so the control unit and bench can decode it.
REQ-039 ARRAY_SIZE and ADDR_WIDTH defaults come from the shared defines.
REQ-040 The block is a single module with no sub-modules; the wait counter and row counter are inline.

Verification
REQ-041 Directed scenarios:
- Basic drain: rst release; start with base=0x0100 and sa_all_done=1. Required: UB writes to 0x0100..0x0103 in cycles 3,5,7,9; capture idx 0..3 in cycles 2,4,6,8; done in cycle 10.
- Late done: start; sa_all_done rises 20 cycles later. Required: busy high throughout; first CAPTURE the cycle after the rise.
- Timeout: TIMEOUT_CYCLES=8; start with sa_all_done=0. Required: timeout_err pulse 8 cycles after WAIT_DONE entry, then IDLE, with no UB writes.
- Arbitration: host_wr_req=1 held with addr 0x0050 during a drain. Required: grant in IDLE, WAIT_DONE, CAPTURE and DONE, never in WRITE; drain_enable=0 on granted cycles.
- Wrap and restart: base=0xFFFE. Required: writes to 0xFFFE, 0xFFFF, 0x0000, 0x0001. A second start mid-drain is ignored and the base is unchanged.
- Reset mid-drain: rst at the second WRITE. Required: next cycle IDLE with all outputs 0 and no done pulse; a new start then completes normally.
